// File: rtl/axil_regmap_if.sv
// AXI4-Lite bus bundle between the PS interconnect and the DAQ register file.
// Slave modport is the register file side, master modport is the bus driver.
interface axil_regmap_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] awaddr;
   logic                  awvalid;
   logic                  awready;

   logic [31:0]           wdata;
   logic [3:0]            wstrb;
   logic                  wvalid;
   logic                  wready;

   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   logic [ADDR_WIDTH-1:0] araddr;
   logic                  arvalid;
   logic                  arready;

   logic [31:0]           rdata;
   logic [1:0]            rresp;
   logic                  rvalid;
   logic                  rready;

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/axil_regmap.sv
// AXI4-Lite register file for the DAQ signal chain.
// RW words drive the flat cfg_regs bus, RO words read back status_regs.
// Write path: AW and W are captured independently; the write commits on the
// first edge where both are available (either held or handshaking now) and
// raises bvalid plus a single-cycle cfg_update pulse on the next cycle.
// Read path: one outstanding read, data registered on the AR handshake edge.
module axil_regmap #(
   parameter int                     N_REGS       = 16,
   parameter int                     ADDR_WIDTH   = 8,
   parameter logic [N_REGS-1:0]      RO_MASK      = {N_REGS{1'b0}},
   parameter logic [N_REGS*32-1:0]   RESET_VALUES = {N_REGS*32{1'b0}}
) (
   input  logic                  clk,
   input  logic                  reset,
   axil_regmap_if.slave          s_axil,
   output logic [N_REGS*32-1:0]  cfg_regs,
   output logic [N_REGS-1:0]     cfg_update,
   input  logic [N_REGS*32-1:0]  status_regs
);

   localparam int         IDX_W  = ADDR_WIDTH - 2;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   // write-side state
   logic              aw_held_q, aw_held_d;
   logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
   logic              w_held_q, w_held_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [31:0]       cfg_q [N_REGS];
   logic [31:0]       cfg_d [N_REGS];
   logic [N_REGS-1:0] cfg_update_q, cfg_update_d;

   // read-side state
   logic              rvalid_q, rvalid_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;

   // handshake / commit helpers
   logic              aw_hs, w_hs, ar_hs, commit;
   logic [IDX_W-1:0]  wr_idx, ar_idx;
   logic [31:0]       wr_data;
   logic [3:0]        wr_strb;

   // byte offset bits carry no meaning for 32-bit word registers
   logic              unused_addr_lsbs;
   assign unused_addr_lsbs = ^{s_axil.awaddr[1:0], s_axil.araddr[1:0]};

   // ready signals are held low during reset so nothing is accepted then
   assign s_axil.awready = !reset && !aw_held_q && !bvalid_q;
   assign s_axil.wready  = !reset && !w_held_q && !bvalid_q;
   assign s_axil.arready = !reset && !rvalid_q;

   assign aw_hs = s_axil.awvalid && s_axil.awready;
   assign w_hs  = s_axil.wvalid && s_axil.wready;
   assign ar_hs = s_axil.arvalid && s_axil.arready;

   assign s_axil.bvalid = bvalid_q;
   assign s_axil.bresp  = bresp_q;
   assign s_axil.rvalid = rvalid_q;
   assign s_axil.rdata  = rdata_q;
   assign s_axil.rresp  = rresp_q;

   assign cfg_update = cfg_update_q;

   assign ar_idx = s_axil.araddr[ADDR_WIDTH-1:2];

   // flatten the register array onto the config bus
   genvar g;
   generate
      for (g = 0; g < N_REGS; g++) begin : g_cfg_out
         assign cfg_regs[32*g +: 32] = cfg_q[g];
      end
   endgenerate

   // write channel capture, commit decode and B response
   always_comb begin
      aw_held_d    = aw_held_q;
      aw_idx_d     = aw_idx_q;
      w_held_d     = w_held_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      cfg_d        = cfg_q;
      cfg_update_d = '0;

      // a held beat wins over the live bus; the live bus only counts while handshaking
      wr_idx  = aw_held_q ? aw_idx_q : s_axil.awaddr[ADDR_WIDTH-1:2];
      wr_data = w_held_q ? wdata_q : s_axil.wdata;
      wr_strb = w_held_q ? wstrb_q : s_axil.wstrb;
      commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);

      if (aw_hs) begin
         aw_held_d = 1'b1;
         aw_idx_d  = s_axil.awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_axil.wdata;
         wstrb_d  = s_axil.wstrb;
      end

      if (bvalid_q && s_axil.bready) begin
         bvalid_d = 1'b0;
      end

      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         // indices beyond N_REGS never match below and stay SLVERR
         bresp_d   = SLVERR;
         for (int i = 0; i < N_REGS; i++) begin
            if (wr_idx == IDX_W'(i) && !RO_MASK[i]) begin
               bresp_d         = OKAY;
               cfg_update_d[i] = 1'b1;
               for (int k = 0; k < 4; k++) begin
                  if (wr_strb[k]) begin
                     cfg_d[i][8*k +: 8] = wr_data[8*k +: 8];
                  end
               end
            end
         end
      end
   end

   // read address decode and R response
   always_comb begin
      rvalid_d = rvalid_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;

      if (rvalid_q && s_axil.rready) begin
         rvalid_d = 1'b0;
      end

      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = '0;
         rresp_d  = SLVERR;
         // cfg_q is the pre-commit value when a write lands on the same edge
         for (int i = 0; i < N_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
               rresp_d = OKAY;
               rdata_d = RO_MASK[i] ? status_regs[32*i +: 32] : cfg_q[i];
            end
         end
      end
   end

   // state registers with synchronous reset; in-flight beats are dropped
   always_ff @(posedge clk) begin
      if (reset) begin
         aw_held_q    <= 1'b0;
         aw_idx_q     <= '0;
         w_held_q     <= 1'b0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         bvalid_q     <= 1'b0;
         bresp_q      <= OKAY;
         cfg_update_q <= '0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
         rresp_q      <= OKAY;
         for (int i = 0; i < N_REGS; i++) begin
            cfg_q[i] <= RESET_VALUES[32*i +: 32];
         end
      end else begin
         aw_held_q    <= aw_held_d;
         aw_idx_q     <= aw_idx_d;
         w_held_q     <= w_held_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         cfg_update_q <= cfg_update_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
         rresp_q      <= rresp_d;
         for (int i = 0; i < N_REGS; i++) begin
            cfg_q[i] <= cfg_d[i];
         end
      end
   end

endmodule

// File: tb/tb_axil_regmap.sv
// Bench for axil_regmap: directed scenarios followed by randomized
// reads/writes, checked against a word-array model of the register map.
module tb_axil_regmap;

   localparam int N  = 16;
   localparam int AW = 8;
   localparam logic [N-1:0] RO = 16'h0004;

   function automatic logic [N*32-1:0] mk_rv();
      logic [N*32-1:0] r;
      r = '0;
      r[3*32 +: 32] = 32'hDEADBEEF;
      r[5*32 +: 32] = 32'h0000A5A5;
      return r;
   endfunction

   localparam logic [N*32-1:0] RV = mk_rv();

   logic clk = 1'b0;
   logic reset;
   logic [N*32-1:0] cfg_regs;
   logic [N*32-1:0] status_regs;
   logic [N-1:0]    cfg_update;

   always #5 clk = ~clk;

   axil_regmap_if #(.ADDR_WIDTH(AW)) bus ();

   axil_regmap #(
      .N_REGS       (N),
      .ADDR_WIDTH   (AW),
      .RO_MASK      (RO),
      .RESET_VALUES (RV)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .s_axil      (bus),
      .cfg_regs    (cfg_regs),
      .cfg_update  (cfg_update),
      .status_regs (status_regs)
   );

   logic [31:0] m_reg  [N];
   logic [31:0] m_stat [N];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < N; i++) m_reg[i] = RV[32*i +: 32];
   endfunction

   function automatic void exp_read(input logic [7:0] addr, output logic [31:0] d, output logic [1:0] r);
      int i;
      i = int'(addr) / 4;
      if (i >= N) begin
         d = 32'h0; r = 2'b10;
      end else if (RO[i]) begin
         d = m_stat[i]; r = 2'b00;
      end else begin
         d = m_reg[i]; r = 2'b00;
      end
   endfunction

   function automatic void m_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                                   output logic [1:0] resp, output logic [N-1:0] upd);
      int i;
      logic [31:0] mask;
      i = int'(addr) / 4;
      upd = '0;
      resp = 2'b10;
      if (i < N && !RO[i]) begin
         resp = 2'b00;
         upd[i] = 1'b1;
         for (int k = 0; k < 4; k++) begin
            if (strb[k]) begin
               mask = 32'hFF << (8 * k);
               m_reg[i] = (m_reg[i] & ~mask) | (data & mask);
            end
         end
      end
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
      logic [1:0]   eresp;
      logic [N-1:0] eupd;
      int           idx;
      bit           ok_aw, ok_w;
      idx = int'(addr) / 4;
      m_write(addr, data, strb, eresp, eupd);
      ok_aw = 1'b0;
      ok_w  = 1'b0;
      fork
         begin
            wait_cycles(aw_dly);
            bus.awaddr  = addr;
            bus.awvalid = 1'b1;
            for (int c = 0; c < 40; c++) begin
               @(negedge clk);
               ok_aw = bus.awready;
               @(posedge clk);
               #1;
               if (ok_aw) break;
            end
            bus.awvalid = 1'b0;
         end
         begin
            wait_cycles(w_dly);
            bus.wdata  = data;
            bus.wstrb  = strb;
            bus.wvalid = 1'b1;
            for (int c = 0; c < 40; c++) begin
               @(negedge clk);
               ok_w = bus.wready;
               @(posedge clk);
               #1;
               if (ok_w) break;
            end
            bus.wvalid = 1'b0;
         end
      join
      check("aw_accept", 32'(ok_aw), 32'd1);
      check("w_accept", 32'(ok_w), 32'd1);
      @(negedge clk);
      check("bvalid_latency", 32'(bus.bvalid), 32'd1);
      check("cfg_update_pulse", 32'(cfg_update), 32'(eupd));
      if (idx < N) check("cfg_word", cfg_regs[32*idx +: 32], m_reg[idx]);
      @(negedge clk);
      check("cfg_update_width", 32'(cfg_update), 32'd0);
      for (int h = 0; h < b_dly; h++) begin
         @(negedge clk);
         check("bvalid_hold", 32'(bus.bvalid), 32'd1);
         check("bresp_hold", 32'(bus.bresp), 32'(eresp));
         check("awready_blocked", 32'(bus.awready), 32'd0);
         check("wready_blocked", 32'(bus.wready), 32'd0);
      end
      check("bresp", 32'(bus.bresp), 32'(eresp));
      bus.bready = 1'b1;
      @(posedge clk);
      #1;
      bus.bready = 1'b0;
      @(negedge clk);
      check("bvalid_clear", 32'(bus.bvalid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic axi_read(input logic [7:0] addr, input int r_dly);
      logic [31:0] ed;
      logic [1:0]  er;
      bit          ok;
      exp_read(addr, ed, er);
      bus.araddr  = addr;
      bus.arvalid = 1'b1;
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         ok = bus.arready;
         @(posedge clk);
         #1;
         if (ok) break;
      end
      bus.arvalid = 1'b0;
      check("ar_accept", 32'(ok), 32'd1);
      @(negedge clk);
      check("rvalid", 32'(bus.rvalid), 32'd1);
      check("rdata", bus.rdata, ed);
      check("rresp", 32'(bus.rresp), 32'(er));
      for (int h = 0; h < r_dly; h++) begin
         @(negedge clk);
         check("rdata_hold", bus.rdata, ed);
         check("arready_blocked", 32'(bus.arready), 32'd0);
      end
      bus.rready = 1'b1;
      @(posedge clk);
      #1;
      bus.rready = 1'b0;
      @(negedge clk);
      check("rvalid_clear", 32'(bus.rvalid), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]   er;
      logic [N-1:0] eu;
      logic [31:0]  pre;

      bus.awaddr = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.araddr = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      for (int i = 0; i < N; i++) begin
         m_stat[i] = $urandom;
         if (i == 2) m_stat[i] = 32'hCAFE0001;
         status_regs[32*i +: 32] = m_stat[i];
      end
      m_reset();

      // reset state
      reset = 1'b1;
      wait_cycles(3);
      @(negedge clk);
      check("rst_awready", 32'(bus.awready), 32'd0);
      check("rst_wready", 32'(bus.wready), 32'd0);
      check("rst_arready", 32'(bus.arready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("rst_bvalid", 32'(bus.bvalid), 32'd0);
      check("rst_rvalid", 32'(bus.rvalid), 32'd0);
      check("rst_cfg_update", 32'(cfg_update), 32'd0);
      check("rst_word3", cfg_regs[3*32 +: 32], 32'hDEADBEEF);
      @(posedge clk);
      #1;
      axi_read(8'h0C, 0);

      // AW first, W four cycles later
      axi_write(8'h04, 32'h12345678, 4'hF, 0, 4, 0);
      check("word1_value", cfg_regs[1*32 +: 32], 32'h12345678);

      // byte-strobe merge
      axi_write(8'h18, 32'h11223344, 4'hF, 0, 0, 0);
      axi_write(8'h1A, 32'hAABBCCDD, 4'b0101, 2, 0, 1);
      check("strb_merge", cfg_regs[6*32 +: 32], 32'h11BB33DD);
      axi_read(8'h18, 1);

      // zero strobe still pulses cfg_update
      axi_write(8'h14, 32'hFFFFFFFF, 4'h0, 1, 1, 0);

      // read-only register
      axi_read(8'h08, 0);
      axi_write(8'h08, 32'h55555555, 4'hF, 0, 0, 0);
      check("ro_cfg_unchanged", cfg_regs[2*32 +: 32], RV[2*32 +: 32]);

      // out of range write with long B stall, out of range read
      axi_write(8'h40, 32'h01020304, 4'hF, 0, 0, 20);
      axi_read(8'h40, 3);
      axi_read(8'h4F, 0);

      // read and write to the same register on the same edge
      pre = m_reg[6];
      bus.awaddr = 8'h18; bus.awvalid = 1'b1;
      bus.wdata = 32'h0F0F0F0F; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      bus.araddr = 8'h18; bus.arvalid = 1'b1;
      @(negedge clk);
      check("same_edge_awready", 32'(bus.awready), 32'd1);
      check("same_edge_arready", 32'(bus.arready), 32'd1);
      @(posedge clk);
      #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
      m_write(8'h18, 32'h0F0F0F0F, 4'hF, er, eu);
      @(negedge clk);
      check("same_edge_rdata_old", bus.rdata, pre);
      check("same_edge_cfg_new", cfg_regs[6*32 +: 32], m_reg[6]);
      check("same_edge_update", 32'(cfg_update), 32'(eu));
      check("same_edge_bvalid", 32'(bus.bvalid), 32'd1);
      check("same_edge_rvalid", 32'(bus.rvalid), 32'd1);
      bus.bready = 1'b1; bus.rready = 1'b1;
      @(posedge clk);
      #1;
      bus.bready = 1'b0; bus.rready = 1'b0;
      @(negedge clk);
      check("same_edge_bclr", 32'(bus.bvalid), 32'd0);
      check("same_edge_rclr", 32'(bus.rvalid), 32'd0);
      @(posedge clk);
      #1;

      // reset one cycle after an AW-only handshake
      bus.awaddr = 8'h00; bus.awvalid = 1'b1;
      @(negedge clk);
      check("aw_only_accept", 32'(bus.awready), 32'd1);
      @(posedge clk);
      #1;
      bus.awvalid = 1'b0;
      wait_cycles(1);
      reset = 1'b1;
      wait_cycles(1);
      reset = 1'b0;
      m_reset();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_rst_bvalid", 32'(bus.bvalid), 32'd0);
      end
      check("post_rst_word6", cfg_regs[6*32 +: 32], m_reg[6]);
      @(posedge clk);
      #1;
      // W first: a stale AW would commit early and block the real AW
      axi_write(8'h00, 32'hA1B2C3D4, 4'hF, 4, 0, 0);
      check("post_rst_word0", cfg_regs[0 +: 32], 32'hA1B2C3D4);

      // back-to-back writes to one register
      axi_write(8'h1C, 32'h00000001, 4'hF, 0, 0, 0);
      axi_write(8'h1C, 32'h00000002, 4'hF, 0, 0, 0);

      // randomized traffic
      for (int n = 0; n < 60; n++) begin
         logic [7:0] a;
         a = 8'($urandom_range(0, 79));
         if ($urandom_range(0, 2) != 0)
            axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                      $urandom_range(0, 3), $urandom_range(0, 2));
         else
            axi_read(a, $urandom_range(0, 2));
      end

      // final sweep of every register
      for (int i = 0; i < N; i++) begin
         axi_read(8'(i * 4), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
